// File: rtl/sun_tracker_fsm.sv
// Light-sensor tracker: deadband + confirmation vote, bounded moves, settle gap.
// Ports: CLK, RST_N, SAMPLE_VALID, LDR_A/B in; LIMIT_CW/CCW in; CW_EN, CCW_EN, STALL out.
module sun_tracker_fsm #(
  parameter int ADC_W        = 12,
  parameter int DEADBAND     = 64,
  parameter int CONFIRM      = 4,
  parameter int MOVE_TICKS   = 50000,
  parameter int SETTLE_TICKS = 20000
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             SAMPLE_VALID,
  input  logic [ADC_W-1:0] LDR_A,
  input  logic [ADC_W-1:0] LDR_B,
  input  logic             LIMIT_CW,
  input  logic             LIMIT_CCW,
  output logic             CW_EN,
  output logic             CCW_EN,
  output logic             STALL
);

  localparam int TMAX = (MOVE_TICKS > SETTLE_TICKS) ?
                        MOVE_TICKS : SETTLE_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int CW   = $clog2(CONFIRM + 1);

  localparam logic signed [ADC_W:0] DB =
    (ADC_W+1)'(DEADBAND);
  localparam logic [TW-1:0] MOVE_END =
    TW'(MOVE_TICKS - 1);
  localparam logic [TW-1:0] SETTLE_END =
    TW'(SETTLE_TICKS - 1);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(CONFIRM);

  typedef enum logic [1:0] {
    IDLE,
    MOVE_CW,
    MOVE_CCW,
    SETTLE
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_CW,
    DIR_CCW
  } dir_t;

  state_t        state;
  dir_t          vote_dir;
  logic [CW-1:0] vote_cnt;
  logic [TW-1:0] timer;

  logic signed [ADC_W:0] diff;
  logic                  cls_cw;
  logic                  cls_ccw;
  dir_t                  cls_dir;

  // Unsigned samples zero-extended so the difference never wraps.
  assign diff = $signed({1'b0, LDR_A}) -
                $signed({1'b0, LDR_B});
  assign cls_cw  = diff > DB;
  assign cls_ccw = diff < -DB;

  always_comb begin
    cls_dir = DIR_NONE;
    if (cls_cw)       cls_dir = DIR_CW;
    else if (cls_ccw) cls_dir = DIR_CCW;
  end

  dir_t          nxt_dir;
  logic [CW-1:0] nxt_cnt;
  logic          confirm;

  // Vote update for the IDLE state; a blocked or balanced sample resets it.
  always_comb begin
    nxt_dir = vote_dir;
    nxt_cnt = vote_cnt;
    if (SAMPLE_VALID) begin
      if (cls_dir == DIR_NONE ||
          (cls_cw && LIMIT_CW) ||
          (cls_ccw && LIMIT_CCW)) begin
        nxt_dir = DIR_NONE;
        nxt_cnt = '0;
      end else if (cls_dir == vote_dir) begin
        if (vote_cnt != CNT_MAX)
          nxt_cnt = vote_cnt + CW'(1);
      end else begin
        nxt_dir = cls_dir;
        nxt_cnt = CW'(1);
      end
    end
    confirm = SAMPLE_VALID &&
              nxt_dir != DIR_NONE &&
              nxt_cnt == CNT_MAX;
  end

  logic timeout;
  logic stop_cw;
  logic stop_ccw;

  assign timeout  = timer == MOVE_END;
  assign stop_cw  = LIMIT_CW || timeout ||
                    (SAMPLE_VALID && !cls_cw);
  assign stop_ccw = LIMIT_CCW || timeout ||
                    (SAMPLE_VALID && !cls_ccw);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      vote_dir <= DIR_NONE;
      vote_cnt <= '0;
      timer    <= '0;
      CW_EN    <= 1'b0;
      CCW_EN   <= 1'b0;
      STALL    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          timer <= '0;
          if (confirm) begin
            vote_dir <= DIR_NONE;
            vote_cnt <= '0;
            if (nxt_dir == DIR_CW) begin
              state <= MOVE_CW;
              CW_EN <= 1'b1;
            end else begin
              state  <= MOVE_CCW;
              CCW_EN <= 1'b1;
            end
          end else begin
            vote_dir <= nxt_dir;
            vote_cnt <= nxt_cnt;
          end
        end
        MOVE_CW: begin
          if (stop_cw) begin
            state <= SETTLE;
            CW_EN <= 1'b0;
            timer <= '0;
            if (timeout) STALL <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        MOVE_CCW: begin
          if (stop_ccw) begin
            state  <= SETTLE;
            CCW_EN <= 1'b0;
            timer  <= '0;
            if (timeout) STALL <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        SETTLE: begin
          if (timer == SETTLE_END) begin
            state    <= IDLE;
            timer    <= '0;
            vote_dir <= DIR_NONE;
            vote_cnt <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          CW_EN  <= 1'b0;
          CCW_EN <= 1'b0;
          timer  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sun_tracker_fsm.sv
// Directed bench for sun_tracker_fsm with an expectation queue.
// Checks {CW_EN,CCW_EN,STALL} #1 after each rising edge.
module tb_sun_tracker_fsm;

  localparam int ADC_W  = 12;
  localparam int MOVE   = 50000;
  localparam int SETTLE = 20000;

  logic             CLK;
  logic             RST_N;
  logic             SAMPLE_VALID;
  logic [ADC_W-1:0] LDR_A;
  logic [ADC_W-1:0] LDR_B;
  logic             LIMIT_CW;
  logic             LIMIT_CCW;
  logic             CW_EN;
  logic             CCW_EN;
  logic             STALL;

  sun_tracker_fsm #(
    .ADC_W(ADC_W),
    .DEADBAND(64),
    .CONFIRM(4),
    .MOVE_TICKS(MOVE),
    .SETTLE_TICKS(SETTLE)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .SAMPLE_VALID(SAMPLE_VALID),
    .LDR_A(LDR_A),
    .LDR_B(LDR_B),
    .LIMIT_CW(LIMIT_CW),
    .LIMIT_CCW(LIMIT_CCW),
    .CW_EN(CW_EN),
    .CCW_EN(CCW_EN),
    .STALL(STALL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string      tag;
    logic [2:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_asserts = 0;
  int   n_fails   = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input string tag,
                      input logic [2:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t       e;
    logic [2:0] obs;
    obs = {CW_EN, CCW_EN, STALL};
    n_asserts++;
    if (sb.size() == 0) begin
      n_fails++;
      $error("FAIL sb_empty: observed %b required an entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fails++;
        $error("FAIL %s: observed %b expected %b",
               e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step(input string tag,
                      input logic [2:0] v);
    push(tag, v);
    tick();
    pop_check();
  endtask

  task automatic strobe(input int a, input int b,
                        input string tag,
                        input logic [2:0] v);
    LDR_A        = ADC_W'(a);
    LDR_B        = ADC_W'(b);
    SAMPLE_VALID = 1'b1;
    push(tag, v);
    tick();
    SAMPLE_VALID = 1'b0;
    pop_check();
  endtask

  task automatic do_reset(input string tag);
    SAMPLE_VALID = 1'b0;
    LIMIT_CW     = 1'b0;
    LIMIT_CCW    = 1'b0;
    RST_N        = 1'b0;
    #1;
    push(tag, 3'b000);
    pop_check();
    tick();
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N        = 1'b0;
    SAMPLE_VALID = 1'b0;
    LDR_A        = '0;
    LDR_B        = '0;
    LIMIT_CW     = 1'b0;
    LIMIT_CCW    = 1'b0;

    // reset state
    tick();
    push("reset_state", 3'b000);
    tick();
    pop_check();
    RST_N = 1'b1;
    step("idle_after_reset", 3'b000);

    // basic CW confirm and balanced stop
    for (int i = 0; i < 3; i++)
      strobe(2000, 1800, "cw_vote", 3'b000);
    strobe(2000, 1800, "cw_confirm", 3'b100);
    step("cw_hold", 3'b100);
    strobe(1900, 1900, "bal_stop", 3'b000);

    // settle length: CWQ strobes every cycle are
    // ignored for SETTLE cycles, then 4 fresh votes
    LDR_A        = 12'd2000;
    LDR_B        = 12'd1800;
    SAMPLE_VALID = 1'b1;
    for (int i = 1; i <= SETTLE + 3; i++) begin
      tick();
      if (i == 1 || i == SETTLE / 2 ||
          i == SETTLE + 3) begin
        push("settle_low", 3'b000);
        pop_check();
      end
    end
    push("after_settle_move", 3'b100);
    tick();
    pop_check();
    SAMPLE_VALID = 1'b0;

    // async reset mid move
    step("pre_reset_move", 3'b100);
    #2;
    RST_N = 1'b0;
    #1;
    push("async_reset_drop", 3'b000);
    pop_check();
    tick();
    RST_N = 1'b1;
    step("idle_post_reset", 3'b000);
    for (int i = 0; i < 3; i++)
      strobe(2000, 1800, "post_rst_vote", 3'b000);
    strobe(2000, 1800, "post_rst_confirm", 3'b100);
    do_reset("rst_skip1");

    // deadband edge
    for (int i = 0; i < 10; i++)
      strobe(1064, 1000, "deadband_in", 3'b000);
    strobe(1000, 1064, "deadband_neg", 3'b000);
    for (int i = 0; i < 3; i++)
      strobe(1065, 1000, "deadband_out", 3'b000);
    strobe(1065, 1000, "deadband_confirm", 3'b100);
    do_reset("rst_skip2");

    // broken vote restarts count
    for (int i = 0; i < 3; i++)
      strobe(2000, 1800, "break_cw", 3'b000);
    for (int i = 0; i < 3; i++)
      strobe(1800, 2000, "break_ccw", 3'b000);
    strobe(1800, 2000, "ccw_confirm", 3'b010);
    step("no_strobe_hold", 3'b010);
    do_reset("rst_skip3");

    // gaps between strobes keep the vote
    strobe(2000, 1800, "gap_v1", 3'b000);
    step("gap_idle", 3'b000);
    strobe(2000, 1800, "gap_v2", 3'b000);
    step("gap_idle2", 3'b000);
    strobe(2000, 1800, "gap_v3", 3'b000);
    strobe(2000, 1800, "gap_confirm", 3'b100);

    // timeout from the above move
    for (int i = 1; i < MOVE - 1; i++) begin
      tick();
      if (i == MOVE / 2) begin
        push("move_mid", 3'b100);
        pop_check();
      end
    end
    step("move_last", 3'b100);
    step("timeout_stall", 3'b001);
    for (int i = 0; i < 5; i++)
      step("stall_sticky", 3'b001);
    do_reset("stall_reset");
    step("stall_cleared", 3'b000);

    // limit switches
    LIMIT_CCW = 1'b1;
    for (int i = 0; i < 8; i++)
      strobe(1000, 3000, "limit_ccw_block", 3'b000);
    for (int i = 0; i < 3; i++)
      strobe(3000, 1000, "limit_cw_vote", 3'b000);
    strobe(3000, 1000, "limit_cw_confirm", 3'b100);
    step("limit_move", 3'b100);
    LIMIT_CW = 1'b1;
    step("limit_cw_stop", 3'b000);
    for (int i = 0; i < 3; i++)
      step("limit_no_stall", 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fails);
    $finish;
  end

endmodule
